// File: rtl/mul_div_unit_pkg.sv
// Shared types and helpers for the EX-stage multiply/divide unit.
package mul_div_unit_pkg;

    // Operation emitted by the decoder alongside its ALU op.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } MulDivOpType;

    // Control state of the unit; exported on the debug port as-is.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL      = 3'd1,
        ST_DIV      = 3'd2,
        ST_FIX      = 3'd3,
        ST_WAIT_ADV = 3'd4
    } md_state_t;

    // Radix-2 iterations needed for 32-bit operands.
    localparam int DIV_ITERS_DEFAULT = 32;

    // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_div_radix2.sv
// Iterative unsigned restoring divider: one shift-subtract step per i_step.
// The 64-bit register holds {partial remainder, dividend/quotient}; quotient
// bits shift in from the bottom as dividend bits shift out of the top.
module mul_div_unit_div_radix2 #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_start,
    input  logic        i_step,
    input  logic        i_abort,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_last
);

    logic [63:0] r_rq;
    logic [31:0] r_divisor;
    logic [31:0] r_count;

    logic [32:0] w_top;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_rq_next;

    // One restoring step: shifted remainder is 33 bits wide so a remainder
    // just under 2^32 cannot overflow when doubled.
    always_comb begin
        w_top     = r_rq[63:31];
        w_ge      = (w_top >= {1'b0, r_divisor});
        w_sub     = w_top[31:0] - r_divisor;
        w_rq_next = w_ge ? {w_sub, r_rq[30:0], 1'b1} : {r_rq[62:0], 1'b0};
    end

    // Load on start, iterate on step, discard everything on abort.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rq      <= 64'd0;
            r_divisor <= 32'd0;
            r_count   <= 32'd0;
        end else if (i_abort) begin
            r_rq      <= 64'd0;
            r_count   <= 32'd0;
        end else if (i_start) begin
            r_rq      <= {32'd0, i_dividend};
            r_divisor <= i_divisor;
            r_count   <= 32'(DIV_ITERS - 1);
        end else if (i_step) begin
            r_rq      <= w_rq_next;
            if (r_count != 32'd0) begin
                r_count <= r_count - 32'd1;
            end
        end
    end

    assign o_quotient  = r_rq[31:0];
    assign o_remainder = r_rq[63:32];
    assign o_last      = (r_count == 32'd0);

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Multiplies commit one cycle after acceptance, divides after 32 iterations
// plus a sign-fix cycle. A flush always beats a commit in the same cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  MulDivOpType EXE_MulDivOp,
    input  logic        EXE_Start,
    input  logic        EXE_Hold,
    input  logic        EXE_Flush,
    input  logic [31:0] EXE_OperandA,
    input  logic [31:0] EXE_OperandB,
    output logic        EXE_MulDivBusy,
    output logic [31:0] EXE_HI,
    output logic [31:0] EXE_LO,
    output logic [2:0]  o_dbg_state
);

    md_state_t   r_state;
    md_state_t   w_next_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic        r_mul_signed;
    logic        r_q_neg;
    logic        r_r_neg;

    logic        w_mul_load;
    logic        w_div_start;
    logic        w_div_step;
    logic        w_div_abort;
    logic        w_hi_we;
    logic        w_lo_we;
    logic [31:0] w_hi_d;
    logic [31:0] w_lo_d;
    logic        w_div_signed;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_product;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_last;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_div_signed = (EXE_MulDivOp == MD_DIV);

    mul_div_unit_div_radix2 #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div_radix2 (
        .clk         (clk),
        .resetn      (resetn),
        .i_start     (w_div_start),
        .i_step      (w_div_step),
        .i_abort     (w_div_abort),
        .i_dividend  (abs_val(EXE_OperandA, w_div_signed)),
        .i_divisor   (abs_val(EXE_OperandB, w_div_signed)),
        .o_quotient  (w_quot),
        .o_remainder (w_rem),
        .o_last      (w_div_last)
    );

    // Product from latched operands; sign-extending to 64 bits makes one
    // multiplier serve both MULT and MULTU. HI/LO is the output register.
    always_comb begin
        w_ext_a   = {{32{r_mul_signed & r_op_a[31]}}, r_op_a};
        w_ext_b   = {{32{r_mul_signed & r_op_b[31]}}, r_op_b};
        w_product = w_ext_a * w_ext_b;
        w_q_fix   = r_q_neg ? (~w_quot + 32'd1) : w_quot;
        w_r_fix   = r_r_neg ? (~w_rem + 32'd1) : w_rem;
    end

    // Next state, stall request and HI/LO write enables.
    always_comb begin
        w_next_state   = r_state;
        EXE_MulDivBusy = 1'b0;
        w_mul_load     = 1'b0;
        w_div_start    = 1'b0;
        w_div_step     = 1'b0;
        w_div_abort    = 1'b0;
        w_hi_we        = 1'b0;
        w_lo_we        = 1'b0;
        w_hi_d         = 32'd0;
        w_lo_d         = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (EXE_Start && !EXE_Flush) begin
                    case (EXE_MulDivOp)
                        MD_MULT, MD_MULTU: begin
                            EXE_MulDivBusy = 1'b1;
                            w_mul_load     = 1'b1;
                            w_next_state   = ST_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            EXE_MulDivBusy = 1'b1;
                            w_div_start    = 1'b1;
                            w_next_state   = ST_DIV;
                        end
                        MD_MTHI: begin
                            w_hi_we      = 1'b1;
                            w_hi_d       = EXE_OperandA;
                            w_next_state = EXE_Hold ? ST_WAIT_ADV : ST_IDLE;
                        end
                        MD_MTLO: begin
                            w_lo_we      = 1'b1;
                            w_lo_d       = EXE_OperandA;
                            w_next_state = EXE_Hold ? ST_WAIT_ADV : ST_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (EXE_Flush) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_hi_we      = 1'b1;
                    w_lo_we      = 1'b1;
                    w_hi_d       = w_product[63:32];
                    w_lo_d       = w_product[31:0];
                    w_next_state = EXE_Hold ? ST_WAIT_ADV : ST_IDLE;
                end
            end
            ST_DIV: begin
                EXE_MulDivBusy = 1'b1;
                if (EXE_Flush) begin
                    w_div_abort  = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_div_step = 1'b1;
                    if (w_div_last) begin
                        w_next_state = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (EXE_Flush) begin
                    w_div_abort  = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_hi_we      = 1'b1;
                    w_lo_we      = 1'b1;
                    w_hi_d       = w_r_fix;
                    w_lo_d       = w_q_fix;
                    w_next_state = EXE_Hold ? ST_WAIT_ADV : ST_IDLE;
                end
            end
            ST_WAIT_ADV: begin
                // The finished instruction is still sitting in EX; its Start
                // must not launch a second operation.
                if (EXE_Flush || !EXE_Hold) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand and sign capture at acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op_a       <= 32'd0;
            r_op_b       <= 32'd0;
            r_mul_signed <= 1'b0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
        end else begin
            if (w_mul_load) begin
                r_op_a       <= EXE_OperandA;
                r_op_b       <= EXE_OperandB;
                r_mul_signed <= (EXE_MulDivOp == MD_MULT);
            end
            if (w_div_start) begin
                r_q_neg <= w_div_signed & (EXE_OperandA[31] ^ EXE_OperandB[31]);
                r_r_neg <= w_div_signed & EXE_OperandA[31];
            end
        end
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_hi_we) begin
                r_hi <= w_hi_d;
            end
            if (w_lo_we) begin
                r_lo <= w_lo_d;
            end
        end
    end

    assign EXE_HI      = r_hi;
    assign EXE_LO      = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit. Inputs change 1ns after the rising edge,
// outputs are sampled 2ns after it.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk;
    logic        resetn;
    MulDivOpType EXE_MulDivOp;
    logic        EXE_Start;
    logic        EXE_Hold;
    logic        EXE_Flush;
    logic [31:0] EXE_OperandA;
    logic [31:0] EXE_OperandB;
    logic        EXE_MulDivBusy;
    logic [31:0] EXE_HI;
    logic [31:0] EXE_LO;
    logic [2:0]  o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int nbusy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mul_div_unit #(.DIV_ITERS(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .EXE_MulDivOp   (EXE_MulDivOp),
        .EXE_Start      (EXE_Start),
        .EXE_Hold       (EXE_Hold),
        .EXE_Flush      (EXE_Flush),
        .EXE_OperandA   (EXE_OperandA),
        .EXE_OperandB   (EXE_OperandB),
        .EXE_MulDivBusy (EXE_MulDivBusy),
        .EXE_HI         (EXE_HI),
        .EXE_LO         (EXE_LO),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_hilo(input string tag);
        check({tag, " HI"}, EXE_HI, exp_hi);
        check({tag, " LO"}, EXE_LO, exp_lo);
    endtask

    task automatic drive_op(input MulDivOpType op, input logic [31:0] a, input logic [31:0] b);
        EXE_MulDivOp = op;
        EXE_OperandA = a;
        EXE_OperandB = b;
        EXE_Start    = 1'b1;
    endtask

    task automatic drive_idle();
        EXE_MulDivOp = MD_NONE;
        EXE_Start    = 1'b0;
    endtask

    // Issue one instruction, hold it in EX while busy, then let it advance.
    // Returns in the first cycle after it left EX, when HI/LO must be valid.
    task automatic do_op(input MulDivOpType op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        @(posedge clk); #1;
        drive_op(op, a, b);
        n = 0;
        #1;
        while (EXE_MulDivBusy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        @(posedge clk); #1;
        drive_idle();
        #1;
    endtask

    initial begin
        resetn       = 1'b0;
        EXE_Hold     = 1'b0;
        EXE_Flush    = 1'b0;
        EXE_OperandA = 32'd0;
        EXE_OperandB = 32'd0;
        drive_idle();
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check_hilo("reset");
        check("reset busy", {31'd0, EXE_MulDivBusy}, 32'd0);
        check("reset state", 32'(o_dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        resetn = 1'b1;

        // MTHI: no stall, visible next cycle
        do_op(MD_MTHI, 32'h12345678, 32'd0, nbusy);
        exp_hi = 32'h12345678;
        check("mthi busy cycles", 32'(nbusy), 32'd0);
        check_hilo("mthi");

        // MTLO killed by a coincident flush
        @(posedge clk); #1;
        drive_op(MD_MTLO, 32'h0BADF00D, 32'd0);
        EXE_Flush = 1'b1;
        #1;
        check("mtlo flush busy", {31'd0, EXE_MulDivBusy}, 32'd0);
        @(posedge clk); #1;
        EXE_Flush = 1'b0;
        drive_idle();
        #1;
        check_hilo("mtlo flushed");

        // MD_NONE has no effect
        do_op(MD_NONE, 32'hDEADBEEF, 32'h1, nbusy);
        check("none busy cycles", 32'(nbusy), 32'd0);
        check_hilo("none");

        // MULTU max x max
        do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, nbusy);
        exp_hi = 32'hFFFFFFFE; exp_lo = 32'h00000001;
        check("multu busy cycles", 32'(nbusy), 32'd1);
        check_hilo("multu");

        // DIV -7/2, back-to-back after the multiply
        do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, nbusy);
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFD;
        check("div busy cycles", 32'(nbusy), 32'd33);
        check_hilo("div -7/2");

        // DIVU 100/0
        do_op(MD_DIVU, 32'd100, 32'd0, nbusy);
        exp_hi = 32'd100; exp_lo = 32'hFFFFFFFF;
        check_hilo("divu 100/0");

        // DIV 0x80000000 / -1
        do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, nbusy);
        exp_hi = 32'd0; exp_lo = 32'h80000000;
        check_hilo("div min/-1");

        // DIV -8/0: negative dividend by zero
        do_op(MD_DIV, 32'hFFFFFFF8, 32'd0, nbusy);
        exp_hi = 32'hFFFFFFF8; exp_lo = 32'h00000001;
        check_hilo("div -8/0");

        // DIVU 50/7 flushed at the 10th iteration
        @(posedge clk); #1;
        drive_op(MD_DIVU, 32'd50, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        check("flush10 pre state", 32'(o_dbg_state), 32'(ST_DIV));
        EXE_Flush = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        EXE_Flush = 1'b0;
        #1;
        check("flush10 state", 32'(o_dbg_state), 32'(ST_IDLE));
        check("flush10 busy", {31'd0, EXE_MulDivBusy}, 32'd0);
        repeat (40) @(posedge clk);
        #2;
        check_hilo("flush10");

        // DIVU 50/7 flushed in the FIX cycle
        @(posedge clk); #1;
        drive_op(MD_DIVU, 32'd50, 32'd7);
        repeat (33) @(posedge clk);
        #1;
        check("flushfix pre state", 32'(o_dbg_state), 32'(ST_FIX));
        EXE_Flush = 1'b1;
        @(posedge clk); #1;
        EXE_Flush = 1'b0;
        drive_idle();
        #1;
        check("flushfix state", 32'(o_dbg_state), 32'(ST_IDLE));
        check_hilo("flushfix");

        // DIVU 50/7 to completion
        do_op(MD_DIVU, 32'd50, 32'd7, nbusy);
        exp_hi = 32'd1; exp_lo = 32'd7;
        check("divu 50/7 busy cycles", 32'(nbusy), 32'd33);
        check_hilo("divu 50/7");

        // MULT -3*5 completing under a 3-cycle hold, Start held high
        @(posedge clk); #1;
        drive_op(MD_MULT, 32'hFFFFFFFD, 32'd5);
        #1;
        check("hold T busy", {31'd0, EXE_MulDivBusy}, 32'd1);
        @(posedge clk); #1;
        EXE_Hold = 1'b1;
        #1;
        check("hold T+1 state", 32'(o_dbg_state), 32'(ST_MUL));
        check("hold T+1 busy", {31'd0, EXE_MulDivBusy}, 32'd0);
        @(posedge clk); #2;
        exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFF1;
        check("hold T+2 state", 32'(o_dbg_state), 32'(ST_WAIT_ADV));
        check_hilo("mult -3*5");
        @(posedge clk); #2;
        check("hold T+3 state", 32'(o_dbg_state), 32'(ST_WAIT_ADV));
        check("hold T+3 busy", {31'd0, EXE_MulDivBusy}, 32'd0);
        @(posedge clk); #1;
        EXE_Hold = 1'b0;
        #1;
        check("hold T+4 state", 32'(o_dbg_state), 32'(ST_WAIT_ADV));
        @(posedge clk); #1;
        drive_idle();
        #1;
        check("hold T+5 state", 32'(o_dbg_state), 32'(ST_IDLE));
        check_hilo("hold after");

        // Reset in the middle of a divide
        @(posedge clk); #1;
        drive_op(MD_DIV, 32'd1000, 32'd10);
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        drive_idle();
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check_hilo("reset mid-div");
        check("reset mid-div busy", {31'd0, EXE_MulDivBusy}, 32'd0);
        check("reset mid-div state", 32'(o_dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        resetn = 1'b1;

        do_op(MD_DIVU, 32'd9, 32'd3, nbusy);
        exp_hi = 32'd0; exp_lo = 32'd3;
        check("divu 9/3 busy cycles", 32'(nbusy), 32'd33);
        check_hilo("divu 9/3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

EX-stage multiply/divide unit that consumes the decoder's MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and owns the architectural HI/LO registers. It sits directly downstream of instruction decode, beside the ALU. Multiplies complete in 2 cycles and divides in 34 cycles. While an operation is in flight, the unit raises a stall request to the hazard logic, and it commits results to HI/LO only when the operation is not flushed.

## Interface
Parameters:
- DIV_ITERS, 32, radix-2 divide iterations; fixed for 32-bit operands.

Ports:
- clk  in  1  core clock; one clock domain.
- resetn  in  1  reset; asynchronous assert, active-low.
- EXE_MulDivOp  in  MulDivOpType  operation of the instruction currently in EX: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- EXE_Start  in  1  a valid, non-bubbled instruction is in EX.
- EXE_Hold  in  1  EX pipeline register is held by a cause other than this unit, e.g. a cache miss.
- EXE_Flush  in  1  exception/eret flush of EX.
- EXE_OperandA  in  32  rs value, already forwarded.
- EXE_OperandB  in  32  rt value, already forwarded.
- EXE_MulDivBusy  out  1  stall request to hazard unit.
- EXE_HI  out  32  current HI, for MFHI.
- EXE_LO  out  32  current LO, for MFLO.

## Operation
States: IDLE, MUL, DIV, FIX, WAIT_ADV.

IDLE:
- EXE_Start with MD_MULT/MULTU: latch the operands and signedness, go to MUL.
- EXE_Start with MD_DIV/DIVU: latch |A|, |B|, the quotient sign (signA^signB) and the remainder sign (signA), load counter=DIV_ITERS-1, go to DIV.
- EXE_Start with MD_MTHI/MTLO: write A into HI/LO at the edge. If EXE_Hold is high, go to WAIT_ADV; otherwise stay in IDLE.

MUL: the 64-bit product is computed from the latched operands (signed or unsigned). {HI,LO}=product at the edge. Next state is WAIT_ADV if EXE_Hold, else IDLE.

DIV: one restoring shift-subtract step per cycle. Decrement the counter; at 0, go to FIX.

FIX: quotient is negated if its sign flag is set; remainder is negated if its sign flag is set. LO=quotient and HI=remainder at the edge. Next state is WAIT_ADV if EXE_Hold, else IDLE.

WAIT_ADV: EXE_Start is ignored, because the same instruction is still in EX. Return to IDLE on the first cycle with EXE_Hold low.

Arithmetic rules:
- 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0.
- Divide by zero raises no exception and gives the sign-corrected restoring result: LO=0xFFFFFFFF for a non-negative dividend (DIV) or any DIVU, LO=0x00000001 for a negative dividend; HI=dividend.

Flush:
- EXE_Flush in any state returns the unit to IDLE next cycle and discards partial results. HI/LO are not written.
- If flush coincides with a commit edge (MUL, FIX, MTHI/MTLO), flush wins and HI/LO are unchanged.

Reset and other boundaries:
- Reset at any time, including mid-divide: state=IDLE, counter=0, HI=LO=0, EXE_MulDivBusy=0.
- MD_NONE with EXE_Start has no effect.

## Timing
EXE_MulDivBusy is combinational:
- 1 in IDLE when EXE_Start is high, EXE_Flush is low and the op is MULT/MULTU/DIV/DIVU.
- 1 in MUL? No: 0 in MUL.
- 1 in DIV.
- 0 in FIX, WAIT_ADV and all other cases.

Latency (T = cycle the op first appears in EX):
- MULT/MULTU: busy during T only. HI/LO are valid from T+2, with 1 stall cycle.
- DIV/DIVU: busy during T through T+32. FIX is cycle T+33. HI/LO are valid from T+34, with 33 stall cycles.
- MTHI/MTLO: no stall; the value is visible from T+1.

Ordering:
- A following MFHI/MFLO in EX at or after the valid cycle reads the new value. Stalls guarantee it never observes a stale value.
- Back-to-back MULT→DIV: the DIV is accepted in the cycle after the MULT commits, provided EXE_Hold is low.

## Structure
- Add to CPU_Defines.svh: the MulDivOpType enum and the DIV_ITERS default.
- The decoder emits MulDivOpType alongside its ALU op.
- Sub-module div_radix2: an iterative unsigned restoring divider (64-bit partial remainder register, 32-bit counter interface, start/abort inputs).
- The state machine, sign handling and HI/LO registers stay in mul_div_unit.
- The multiply is a single registered `*` so synthesis can map it to DSP blocks.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → busy for exactly 1 cycle; HI=0xFFFFFFFE, LO=0x00000001.
- MULT −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV −7/2 → busy for 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 → LO=0xFFFFFFFF, HI=100.
- DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- DIVU 50/7 with EXE_Flush asserted at DIV iteration 10 → unit in IDLE next cycle; HI/LO keep their prior values. Repeat with flush in the FIX cycle → HI/LO unchanged.
- MULT completing while EXE_Hold=1 for 3 cycles, with EXE_Start held high → exactly one commit, no restart, IDLE after Hold drops.
- Reset asserted mid-DIV → HI=LO=0 and busy=0 immediately. A new DIVU 9/3 afterwards gives LO=3, HI=0.
